ofdm_symbol_demapper: RTL
=========================

// Module: ofdm_symbol_demapper
// PURPOSE
//  Sits directly downstream of the receive equalizer. Accepts one equalized 64-bin OFDM symbol
//  per valid cycle, extracts the 48 802.11a data subcarriers, makes hard QPSK/16-QAM decisions
//  and streams the decided bits out over a valid/ready interface through a 2-symbol ping-pong buffer.
// PARAMETERS
//  EQ_WIDTH     32  width of each equalized re/im sample (signed two's complement)
//  FFTSIZE      64  bins per input symbol
//  NDATA        48  data subcarriers per symbol
//  DATASYMBOLS  12  data symbols per frame; bit_last_o marks end of frame
//  OUT_BITS     32  bits per output beat (must divide 96)
// PORTS
//  clk_i          in   1                  clock
//  rst_ni         in   1                  asynchronous active-low reset
//  eq_re_i        in   EQ_WIDTH*FFTSIZE   equalized real, bin k at [(k+1)*EQ_WIDTH-1 -: EQ_WIDTH]
//  eq_im_i        in   EQ_WIDTH*FFTSIZE   equalized imag, same packing
//  eq_valid_i     in   FFTSIZE            per-bin valid; symbol accepted when eq_valid_i[0]=1
//  mod_i          in   1                  0=QPSK, 1=16-QAM; sampled on first symbol of frame
//  thr_i          in   EQ_WIDTH           16-QAM inner/outer threshold (unsigned magnitude)
//  bit_data_o     out  OUT_BITS           decided bits, LSB first
//  bit_valid_o    out  1                  beat valid
//  bit_ready_i    in   1                  sink ready
//  bit_last_o     out  1                  last beat of symbol DATASYMBOLS of frame
//  overflow_o     out  1                  sticky: symbol dropped because both buffers full
// BEHAVIOUR
//  - Reset (rst_ni=0, async): all outputs 0; buffers empty; sym_cnt=0; FSM IDLE; overflow cleared.
//  - Data bin order (subcarrier -26..26, pilots +-7,+-21 and DC skipped):
//    38-42, 44-56, 58-63, 1-6, 8-20, 22-26. Carrier n = position 0..47 in this list.
//  - QPSK: carrier n -> bits[2n]=(re>=0), bits[2n+1]=(im>=0); 96 bits, 3 beats of 32.
//  - 16-QAM: bits[4n]=(re>=0), bits[4n+1]=(|re|<thr_i), bits[4n+2]=(im>=0), bits[4n+3]=(|im|<thr_i);
//    192 bits, 6 beats. |x| of most-negative value saturates to max positive.
//  - Capture: on eq_valid_i[0] decisions written in the same cycle into buffer wr_sel together
//    with the frame's mod flag; buffer marked full next cycle. Latency input valid -> first
//    bit_valid_o = 1 cycle when the output is idle.
//  - Frame: sym_cnt counts accepted symbols 0..DATASYMBOLS-1, wraps to 0; mod_i/thr_i latched
//    when sym_cnt==0. Dropped symbols still advance sym_cnt (frame alignment kept).
//  - Buffer: fill count 0..2; wr_sel toggles per write, rd_sel per fully sent symbol.
//    Write and last-beat read in same cycle: count unchanged, both pointers toggle.
//    Write while count==2 and no read completion: symbol dropped, overflow_o<=1 (sticky).
//  - Output FSM: IDLE -> SEND when count>0 (bit_valid_o=1, beat=0). In SEND a beat advances
//    only on bit_valid_o&&bit_ready_i; bit_data_o/bit_last_o stable while stalled. After
//    final beat (2 or 5): SEND if count stays >0 (back-to-back, no bubble) else IDLE.
//  - bit_last_o=1 only on final beat of a symbol tagged last-of-frame at capture.
//  - eq_valid_i bits other than [0] ignored.
// CONFIGURATION
//  OFDM_DEMAP_PILOT_EN defined: adds outputs pilot_sign_o[3:0] (re>=0 of bins 43,57,7,21 in that
//  order, bit0=bin 43) and pilot_valid_o, both registered 1 cycle after eq_valid_i[0], reset 0;
//  pilot_valid_o is a 1-cycle pulse, not dropped on overflow.
//  Undefined: ports absent, no pilot logic; data path identical.
// TESTING
//  T1 QPSK, all data bins re=+1000,im=-1000, ready=1 -> 3 beats 32'h55555555, valid 1 cycle after input.
//  T2 16-QAM thr=2000, data re=+1000,im=-3000 -> nibble 4'b0011 per carrier, 6 beats 32'h33333333.
//  T3 12 QPSK symbols ready=1 -> 36 beats, bit_last_o only on beat 36; 13th symbol starts new frame.
//  T4 ready=0, 3 symbols -> overflow_o=1, first 2 symbols later delivered intact, third lost.
//  T5 ready toggling 1/0 each cycle -> data stable during stalls, no beat lost or duplicated.
//  T6 rst_ni low mid-SEND -> outputs 0 asynchronously; after release next symbol is sym_cnt=0.

Source files
------------

// File: rtl/ofdm_symbol_demapper_if.sv
// Equalizer-to-demapper bus: equalized bins and controls in, decided bit stream out.
// Pilot sign outputs exist only when OFDM_DEMAP_PILOT_EN is defined.
interface ofdm_symbol_demapper_if #(
  parameter int unsigned EQ_WIDTH = 32,
  parameter int unsigned FFTSIZE  = 64,
  parameter int unsigned OUT_BITS = 32
);
  logic [EQ_WIDTH*FFTSIZE-1:0] eq_re_i;
  logic [EQ_WIDTH*FFTSIZE-1:0] eq_im_i;
  logic [FFTSIZE-1:0]          eq_valid_i;
  logic                        mod_i;
  logic [EQ_WIDTH-1:0]         thr_i;
  logic [OUT_BITS-1:0]         bit_data_o;
  logic                        bit_valid_o;
  logic                        bit_ready_i;
  logic                        bit_last_o;
  logic                        overflow_o;
`ifdef OFDM_DEMAP_PILOT_EN
  logic [3:0]                  pilot_sign_o;
  logic                        pilot_valid_o;
`endif

  modport master (
    output eq_re_i, eq_im_i, eq_valid_i, mod_i, thr_i, bit_ready_i,
`ifdef OFDM_DEMAP_PILOT_EN
    input  pilot_sign_o, pilot_valid_o,
`endif
    input  bit_data_o, bit_valid_o, bit_last_o, overflow_o
  );

  modport slave (
    input  eq_re_i, eq_im_i, eq_valid_i, mod_i, thr_i, bit_ready_i,
`ifdef OFDM_DEMAP_PILOT_EN
    output pilot_sign_o, pilot_valid_o,
`endif
    output bit_data_o, bit_valid_o, bit_last_o, overflow_o
  );
endinterface

// File: rtl/ofdm_symbol_demapper.sv
// Hard-decision QPSK/16-QAM demapper for 48 802.11a data carriers with a 2-symbol output buffer.
// Optional OFDM_DEMAP_PILOT_EN adds registered pilot sign outputs.
module ofdm_symbol_demapper #(
  parameter int unsigned EQ_WIDTH    = 32,
  parameter int unsigned FFTSIZE     = 64,
  parameter int unsigned NDATA       = 48,
  parameter int unsigned DATASYMBOLS = 12,
  parameter int unsigned OUT_BITS    = 32
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  ofdm_symbol_demapper_if.slave  bus
);
  localparam int unsigned QpskBits  = 2 * NDATA;
  localparam int unsigned QamBits   = 4 * NDATA;
  localparam int unsigned QpskBeats = QpskBits / OUT_BITS;
  localparam int unsigned QamBeats  = QamBits / OUT_BITS;
  localparam int unsigned BeatW     = (QamBeats > 1) ? $clog2(QamBeats) : 1;
  localparam int unsigned SymW      = (DATASYMBOLS > 1) ? $clog2(DATASYMBOLS) : 1;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  function automatic int unsigned data_bin(input int unsigned n);
    if (n < 5)       return 38 + n;
    else if (n < 18) return 44 + n - 5;
    else if (n < 24) return 58 + n - 18;
    else if (n < 30) return 1 + n - 24;
    else if (n < 43) return 8 + n - 30;
    else             return 22 + n - 43;
  endfunction

  // Magnitude with the most-negative code clamped to the largest positive value.
  function automatic logic [EQ_WIDTH-1:0] mag(input logic [EQ_WIDTH-1:0] x);
    if (!x[EQ_WIDTH-1]) return x;
    if (x == {1'b1, {(EQ_WIDTH-1){1'b0}}}) return {1'b0, {(EQ_WIDTH-1){1'b1}}};
    return -x;
  endfunction

  state_e                    state_q, state_d;
  logic [SymW-1:0]           sym_cnt_q;
  logic                      mod_q;
  logic [EQ_WIDTH-1:0]       thr_q;
  logic [1:0][QamBits-1:0]   buf_q;
  logic [1:0]                buf_mod_q, buf_last_q;
  logic                      wr_sel_q, rd_sel_q;
  logic [1:0]                count_q, count_d;
  logic [BeatW-1:0]          beat_q, beat_d;
  logic                      overflow_q;

  logic                      sym_in, frame_start, cur_mod;
  logic [EQ_WIDTH-1:0]       cur_thr;
  logic [QpskBits-1:0]       qpsk_bits;
  logic [QamBits-1:0]        qam_bits, dec_bits;
  logic                      last_beat, fire, rd_done, wr_ok;

  assign sym_in      = bus.eq_valid_i[0];
  assign frame_start = (sym_cnt_q == '0);
  // The first symbol of a frame is decided with the live controls it also latches.
  assign cur_mod     = frame_start ? bus.mod_i : mod_q;
  assign cur_thr     = frame_start ? bus.thr_i : thr_q;

  for (genvar n = 0; n < NDATA; n++) begin : g_car
    localparam int unsigned Bin = data_bin(n);
    logic [EQ_WIDTH-1:0] re, im;
    assign re = bus.eq_re_i[Bin*EQ_WIDTH +: EQ_WIDTH];
    assign im = bus.eq_im_i[Bin*EQ_WIDTH +: EQ_WIDTH];
    assign qpsk_bits[2*n +: 2] = {~im[EQ_WIDTH-1], ~re[EQ_WIDTH-1]};
    assign qam_bits[4*n +: 4]  = {(mag(im) < cur_thr), ~im[EQ_WIDTH-1],
                                  (mag(re) < cur_thr), ~re[EQ_WIDTH-1]};
  end

  assign dec_bits  = cur_mod ? qam_bits : QamBits'(qpsk_bits);
  assign last_beat = (beat_q == (buf_mod_q[rd_sel_q] ? BeatW'(QamBeats - 1)
                                                     : BeatW'(QpskBeats - 1)));
  assign fire      = (state_q == StSend) && bus.bit_ready_i;
  assign rd_done   = fire && last_beat;
  assign wr_ok     = sym_in && ((count_q != 2'd2) || rd_done);

  always_comb begin
    count_d = count_q;
    unique case ({wr_ok, rd_done})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    unique case (state_q)
      StIdle: begin
        if (count_d != 2'd0) begin
          state_d = StSend;
          beat_d  = '0;
        end
      end
      StSend: begin
        if (fire) begin
          if (last_beat) begin
            beat_d = '0;
            if (count_d == 2'd0) state_d = StIdle;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      beat_q     <= '0;
      count_q    <= '0;
      sym_cnt_q  <= '0;
      mod_q      <= 1'b0;
      thr_q      <= '0;
      buf_q      <= '0;
      buf_mod_q  <= '0;
      buf_last_q <= '0;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      count_q <= count_d;
      if (sym_in) begin
        sym_cnt_q <= (sym_cnt_q == SymW'(DATASYMBOLS - 1)) ? '0 : sym_cnt_q + 1'b1;
        if (frame_start) begin
          mod_q <= bus.mod_i;
          thr_q <= bus.thr_i;
        end
        if (wr_ok) begin
          buf_q[wr_sel_q]      <= dec_bits;
          buf_mod_q[wr_sel_q]  <= cur_mod;
          buf_last_q[wr_sel_q] <= (sym_cnt_q == SymW'(DATASYMBOLS - 1));
          wr_sel_q             <= ~wr_sel_q;
        end else begin
          overflow_q <= 1'b1;
        end
      end
      if (rd_done) rd_sel_q <= ~rd_sel_q;
    end
  end

  assign bus.bit_valid_o = (state_q == StSend);
  assign bus.bit_data_o  = bus.bit_valid_o ? buf_q[rd_sel_q][beat_q*OUT_BITS +: OUT_BITS] : '0;
  assign bus.bit_last_o  = bus.bit_valid_o && last_beat && buf_last_q[rd_sel_q];
  assign bus.overflow_o  = overflow_q;

`ifdef OFDM_DEMAP_PILOT_EN
  logic [3:0] pilot_sign_q;
  logic       pilot_valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pilot_sign_q  <= '0;
      pilot_valid_q <= 1'b0;
    end else begin
      pilot_valid_q <= sym_in;
      if (sym_in) begin
        pilot_sign_q <= {~bus.eq_re_i[22*EQ_WIDTH-1], ~bus.eq_re_i[8*EQ_WIDTH-1],
                         ~bus.eq_re_i[58*EQ_WIDTH-1], ~bus.eq_re_i[44*EQ_WIDTH-1]};
      end
    end
  end

  assign bus.pilot_sign_o  = pilot_sign_q;
  assign bus.pilot_valid_o = pilot_valid_q;
`endif

  // Bins outside the data set and per-bin valids above bit 0 are intentionally unused.
  logic unused_in;
  assign unused_in = ^{bus.eq_valid_i[FFTSIZE-1:1], bus.eq_re_i, bus.eq_im_i};
endmodule
